// File: rtl/layer_hdr_pkg.sv
// Shared constants, FSM encoding and header helpers for the layer header
// memories and their read-side sequencer.
package layer_hdr_pkg;

    localparam int unsigned NUM_LAYERS = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned EN_REG     = 0;
    localparam int unsigned EN_BIT     = 15;
    localparam int unsigned HDR_W      = NUM_REGS * DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } fetch_state_e;

    function automatic logic [DATA_W-1:0] hdr_slice(input logic [HDR_W-1:0] hdr,
                                                    input int unsigned      r);
        return hdr[r*DATA_W +: DATA_W];
    endfunction

    function automatic logic hdr_enabled(input logic [HDR_W-1:0] hdr);
        logic [DATA_W-1:0] en_reg;
        en_reg = hdr_slice(hdr, EN_REG);
        return en_reg[EN_BIT];
    endfunction

endpackage

// File: rtl/layer_header_fetch.sv
// Per-frame layer walker: broadcasts a read address to the header memories,
// skips disabled layers and hands each enabled header out over valid/ready.
module layer_header_fetch
    import layer_hdr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [HDR_W-1:0]  rd_data,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [ADDR_W-1:0] hdr_layer,
    output logic [HDR_W-1:0]  hdr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_LAYER = ADDR_W'(NUM_LAYERS - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] layer_idx_q, layer_idx_d;
    logic [ADDR_W-1:0] hdr_layer_q, hdr_layer_d;
    logic [HDR_W-1:0]  hdr_data_q, hdr_data_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              last_w;

    assign last_w = (layer_idx_q == LAST_LAYER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            layer_idx_q  <= '0;
            hdr_layer_q  <= '0;
            hdr_data_q   <= '0;
            hdr_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_idx_q  <= layer_idx_d;
            hdr_layer_q  <= hdr_layer_d;
            hdr_data_q   <= hdr_data_d;
            hdr_valid_q  <= hdr_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // frame_start overrides everything, including a same-cycle handshake.
    always_comb begin
        state_d      = state_q;
        layer_idx_d  = layer_idx_q;
        hdr_layer_d  = hdr_layer_q;
        hdr_data_d   = hdr_data_q;
        hdr_valid_d  = hdr_valid_q;
        frame_done_d = 1'b0;
        if (frame_start) begin
            state_d     = SCAN;
            layer_idx_d = '0;
            hdr_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                SCAN: begin
                    if (hdr_enabled(rd_data)) begin
                        hdr_data_d  = rd_data;
                        hdr_layer_d = layer_idx_q;
                        hdr_valid_d = 1'b1;
                        state_d     = PRESENT;
                    end else if (last_w) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        layer_idx_d = layer_idx_q + ADDR_W'(1);
                    end
                end
                PRESENT: begin
                    if (hdr_valid_q && hdr_ready) begin
                        hdr_valid_d = 1'b0;
                        if (last_w) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            layer_idx_d = layer_idx_q + ADDR_W'(1);
                            state_d     = SCAN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_addr    = layer_idx_q;
        hdr_valid  = hdr_valid_q;
        hdr_layer  = hdr_layer_q;
        hdr_data   = hdr_data_q;
        frame_done = frame_done_q;
        busy       = (state_q != IDLE);
    end

endmodule
